// File: rtl/iob_eth_mii_mgmt_pkg.sv
// iob_eth_mii_mgmt_pkg: shared state encoding, MDIO frame codes and field lengths
package iob_eth_mii_mgmt_pkg;

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int PRE_LEN  = 32;
    localparam int HDR_LEN  = 14;
    localparam int TA_LEN   = 2;
    localparam int DATA_LEN = 16;

    function automatic logic [5:0] last_bit(state_t s);
        return s == PRE ? 6'(PRE_LEN - 1) :
               s == HDR ? 6'(HDR_LEN - 1) :
               s == TA  ? 6'(TA_LEN - 1)  : 6'(DATA_LEN - 1);
    endfunction

endpackage

// File: rtl/iob_eth_mii_mgmt_sync.sv
// iob_sync: two-flop synchronizer with clock enable
module iob_sync #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] signal_i,
    output logic [DATA_W-1:0] signal_o
);

    logic [DATA_W-1:0] meta;

    // two register stages to resolve metastability of the asynchronous input
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            meta     <= RST_VAL;
            signal_o <= RST_VAL;
        end else if (cke_i) begin
            meta     <= signal_i;
            signal_o <= meta;
        end
    end

endmodule

// File: rtl/iob_eth_mii_mgmt.sv
// iob_eth_mii_mgmt: MDIO management frame master (clause 22 read/write)
module iob_eth_mii_mgmt
    import iob_eth_mii_mgmt_pkg::*;
#(
    parameter int MIN_DIV = 4
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        cke_i,
    input  logic [7:0]  clkdiv_i,
    input  logic        no_pre_i,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [4:0]  phy_addr_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [15:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    state_t      state, state_nxt;
    logic [7:0]  div, half;
    logic [5:0]  bit_cnt;
    logic        mdc, op, mdio_s, bit_end, last;
    logic [4:0]  phy, regad;
    logic [15:0] wdata, shift;
    logic [13:0] hdr;

    iob_sync #(.DATA_W(1), .RST_VAL(1'b1)) mdio_sync (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .signal_i (mdio_i),
        .signal_o (mdio_s)
    );

    assign bit_end   = mdc && div == half - 8'd1;
    assign last      = bit_end && bit_cnt == last_bit(state);
    assign hdr       = {ST_CODE, op ? OP_WRITE : OP_READ, phy, regad};
    assign busy_o    = state != IDLE && state != DONE;
    assign done_o    = state == DONE;
    assign mdc_o     = mdc;
    assign mdio_oe_o = busy_o && (op || state == PRE || state == HDR);
    assign mdio_o    = state == HDR          ? hdr[4'd13 - bit_cnt[3:0]] :
                       (state == TA && op)   ? bit_cnt == 6'd0 :
                       (state == DATA && op) ? wdata[4'd15 - bit_cnt[3:0]] : 1'b1;

    // frame sequencing: each field advances when its bit counter expires
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start_i ? (no_pre_i ? HDR : PRE) : IDLE;
            PRE:     state_nxt = last ? HDR : PRE;
            HDR:     state_nxt = last ? TA : HDR;
            TA:      state_nxt = last ? DATA : TA;
            DATA:    state_nxt = last ? DONE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= IDLE;
        else if (cke_i) state <= state_nxt;
    end

    // command latch, MDC divider, bit counter and read shift register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            div     <= '0;
            bit_cnt <= '0;
            mdc     <= 1'b0;
            op      <= 1'b0;
            phy     <= '0;
            regad   <= '0;
            wdata   <= '0;
            half    <= 8'(MIN_DIV);
            shift   <= '0;
            rdata_o <= '0;
        end else if (cke_i) begin
            if (state == IDLE && start_i) begin
                op      <= op_i;
                phy     <= phy_addr_i;
                regad   <= reg_addr_i;
                wdata   <= wdata_i;
                half    <= clkdiv_i < 8'(MIN_DIV) ? 8'(MIN_DIV) : clkdiv_i;
                div     <= '0;
                bit_cnt <= '0;
                mdc     <= 1'b0;
            end else if (busy_o) begin
                div     <= div == half - 8'd1 ? 8'd0 : div + 8'd1;
                mdc     <= div == half - 8'd1 ? ~mdc : mdc;
                bit_cnt <= last ? 6'd0 : bit_end ? bit_cnt + 6'd1 : bit_cnt;
                if (bit_end && state == DATA && !op) shift <= {shift[14:0], mdio_s};
                if (last && state == DATA && !op) rdata_o <= {shift[14:0], mdio_s};
            end
        end
    end

endmodule

// File: tb/tb_iob_eth_mii_mgmt.sv
// tb_iob_eth_mii_mgmt: scoreboard bench with MDIO PHY model for iob_eth_mii_mgmt
module tb_iob_eth_mii_mgmt;

    logic        clk = 0, arst_n = 0, cke = 1, no_pre = 0, start = 0, op = 0, mdio_in = 1;
    logic [7:0]  clkdiv = 8'd4;
    logic [4:0]  phy_addr = '0, reg_addr = '0;
    logic [15:0] wdata = '0, rdata, phy_data = '0, last_rdata = '0;
    logic        busy, done, mdc, mdio_out, mdio_oe;
    int          checks = 0, errors = 0, cyc = 0, done_cnt = 0;

    typedef struct {
        int          done_cyc;
        logic [15:0] rdata;
        logic [63:0] frame;
        logic [63:0] mask;
        logic [63:0] oe;
        int          n;
        int          d;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;

    iob_eth_mii_mgmt #(.MIN_DIV(4)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .cke_i      (cke),
        .clkdiv_i   (clkdiv),
        .no_pre_i   (no_pre),
        .start_i    (start),
        .op_i       (op),
        .phy_addr_i (phy_addr),
        .reg_addr_i (reg_addr),
        .wdata_i    (wdata),
        .busy_o     (busy),
        .done_o     (done),
        .rdata_o    (rdata),
        .mdc_o      (mdc),
        .mdio_o     (mdio_out),
        .mdio_oe_o  (mdio_oe),
        .mdio_i     (mdio_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the management frame as a bit string, duration from bit count and MDC period
    function automatic exp_t model(logic o, logic [4:0] pa, logic [4:0] ra, logic [15:0] wd,
                                   logic [7:0] cd, logic np, int stall, int start_cyc,
                                   logic [15:0] rd);
        exp_t e;
        e.d        = cd < 8'd4 ? 4 : int'(cd);
        e.n        = np ? 32 : 64;
        e.frame    = {32'hFFFF_FFFF, 2'b01, (o ? 2'b01 : 2'b10), pa, ra,
                      (o ? 2'b10 : 2'b00), (o ? wd : 16'h0)};
        e.oe       = np ? 64'hFFFF_FFFF : '1;
        e.oe       = o ? e.oe : (e.oe & ~64'h3FFFF);
        e.mask     = e.oe;
        e.done_cyc = start_cyc + 1 + e.n * 2 * e.d + stall;
        e.rdata    = rd;
        return e;
    endfunction

    task automatic issue(logic o, logic [4:0] pa, logic [4:0] ra, logic [15:0] wd,
                         logic [7:0] cd, logic np, int stall, logic accept);
        @(posedge clk); #1;
        op = o; phy_addr = pa; reg_addr = ra; wdata = wd; clkdiv = cd; no_pre = np; start = 1;
        if (accept) begin
            if (!o) last_rdata = phy_data;
            q.push_back(model(o, pa, ra, wd, cd, np, stall, cyc, last_rdata));
        end
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(int budget);
        int t0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == t0; i++) @(posedge clk);
        if (done_cnt == t0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
    endtask

    // PHY model: after the MAC releases MDIO, bits 2..17 (after TA) carry phy_data MSB first
    logic phy_act = 0, phy_prev_mdc = 0;
    int   k = 0;
    always @(negedge clk) begin
        if (arst_n && busy && !mdio_oe) begin
            if (!phy_act) begin
                phy_act = 1;
                k = 0;
            end else if (phy_prev_mdc && !mdc) k++;
        end else phy_act = 0;
        mdio_in = (phy_act && k >= 2 && k < 18) ? phy_data[17 - k] : 1'b1;
        phy_prev_mdc = mdc;
    end

    // Monitor: captures the frame at MDC rising edges, checks phase lengths and completion
    logic        prev_mdc = 0, prev_busy = 0, prev_mdio = 1, prev_cke = 1;
    int          run = 0, cap_n = 0;
    logic [63:0] cap_f = '0, cap_oe = '0;
    always @(negedge clk) begin
        if (!arst_n) begin
            prev_busy = 0;
            prev_mdc = 0;
            prev_mdio = 1;
            cap_n = 0;
        end else begin
            if (busy && !prev_busy) begin
                run = 1;
                cap_n = 0;
                cap_f = '0;
                cap_oe = '0;
            end else if (busy || prev_busy) begin
                if (mdc != prev_mdc) begin
                    if (q.size() > 0) chk("half_period", 64'(run), 64'(q[0].d));
                    run = 1;
                    if (mdc) begin
                        cap_f = {cap_f[62:0], mdio_out};
                        cap_oe = {cap_oe[62:0], mdio_oe};
                        cap_n++;
                    end
                end else if (prev_cke) run++;
                if (busy && mdio_out != prev_mdio) chk("mdio_edge", {62'd0, prev_mdc, mdc}, 64'd2);
            end
            if (done) begin
                done_cnt++;
                if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else begin
                    e_mon = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e_mon.done_cyc));
                    chk("rdata", 64'(rdata), 64'(e_mon.rdata));
                    chk("frame_len", 64'(cap_n), 64'(e_mon.n));
                    chk("frame_bits", cap_f & e_mon.mask, e_mon.frame & e_mon.mask);
                    chk("frame_oe", cap_oe, e_mon.oe);
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
            end
            prev_busy = busy;
            prev_mdc = mdc;
            prev_mdio = mdio_out;
        end
        prev_cke = cke;
    end

    initial begin
        logic       o, np;
        logic [7:0] cd;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_mdio", 64'(mdio_out), 64'd1);
        chk("rst_oe", 64'(mdio_oe), 64'd0);
        arst_n = 1;
        repeat (2) @(posedge clk);

        issue(1'b1, 5'd1, 5'd0, 16'h1140, 8'd4, 1'b0, 0, 1'b1);
        wait_done(5000);

        phy_data = 16'h0022;
        issue(1'b0, 5'd3, 5'd2, 16'h0, 8'd4, 1'b0, 0, 1'b1);
        wait_done(5000);

        issue(1'b1, 5'd7, 5'd9, 16'hA5C3, 8'd0, 1'b1, 0, 1'b1);
        wait_done(5000);

        phy_data = 16'hDEAD;
        issue(1'b1, 5'd2, 5'd4, 16'h5555, 8'd4, 1'b0, 0, 1'b1);
        repeat (8) @(posedge clk);
        issue(1'b0, 5'd5, 5'd6, 16'h0, 8'd4, 1'b0, 0, 1'b0);
        wait_done(5000);
        repeat (1200) @(posedge clk);
        chk("idle_mdc", 64'(mdc), 64'd0);
        chk("idle_mdio", 64'(mdio_out), 64'd1);
        chk("idle_oe", 64'(mdio_oe), 64'd0);

        phy_data = 16'h8421;
        issue(1'b0, 5'd17, 5'd30, 16'h0, 8'd4, 1'b0, 20, 1'b1);
        repeat (100) @(posedge clk);
        #1 cke = 0;
        repeat (20) @(posedge clk);
        #1 cke = 1;
        wait_done(5000);

        issue(1'b1, 5'd9, 5'd3, 16'hFBFF, 8'd4, 1'b0, 0, 1'b1);
        repeat (429) @(posedge clk);
        #3 arst_n = 0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_rdata", 64'(rdata), 64'd0);
        chk("arst_mdc", 64'(mdc), 64'd0);
        chk("arst_mdio", 64'(mdio_out), 64'd1);
        chk("arst_oe", 64'(mdio_oe), 64'd0);
        q.delete();
        last_rdata = '0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1;
        repeat (1200) @(posedge clk);
        phy_data = 16'h3C5A;
        issue(1'b0, 5'd11, 5'd12, 16'h0, 8'd5, 1'b0, 0, 1'b1);
        wait_done(5000);

        for (int i = 0; i < 8; i++) begin
            o = 1'($urandom_range(0, 1));
            np = 1'($urandom_range(0, 1));
            cd = 8'($urandom_range(0, 7));
            phy_data = 16'($urandom);
            issue(o, 5'($urandom), 5'($urandom), 16'($urandom), cd, np, 0, 1'b1);
            wait_done(5000);
        end

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
